// File: rtl/aes_subbytes_seq_pkg.sv
// Shared types and constants for the SubBytes engine: FSM states, FIPS-197
// forward/inverse S-box tables and the legal-parameter check.
package aes_sbox_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sb_state_t;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Only 16-byte round state and 4-byte key words are meaningful block sizes.
  function automatic bit params_ok(input int nbytes, input int lanes);
    return ((nbytes == 4) || (nbytes == 16)) && (lanes > 0) &&
           (lanes <= nbytes) && ((nbytes % lanes) == 0);
  endfunction

endpackage

// File: rtl/aes_subbytes_seq_if.sv
// Block handshake bundle between a SubBytes requester (master) and the engine (slave).
interface aes_subbytes_seq_if #(
  parameter int NBYTES = 16
);
  logic                in_valid;
  logic                in_ready;
  logic                in_inv;
  logic [8*NBYTES-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [8*NBYTES-1:0] out_data;
  logic                abort;
  logic                busy;

  modport master (
    output in_valid, in_inv, in_data, out_ready, abort,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_inv, in_data, out_ready, abort,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_subbytes_seq_sbox.sv
// One combinational S-box lane; inv selects the inverse table.
module aes_sbox_fi
  import aes_sbox_pkg::*;
(
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  always_comb begin
    dout = inv ? SBOX_INV[din] : SBOX_FWD[din];
  end

endmodule

// File: rtl/aes_subbytes_seq.sv
// Handshaked SubBytes engine: LANES shared S-boxes sweep an NBYTES block over
// NBYTES/LANES beats, then present the full result for one output handshake.
module aes_subbytes_seq
  import aes_sbox_pkg::*;
#(
  parameter int NBYTES = 16,
  parameter int LANES  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  aes_subbytes_seq_if.slave bus
);

  localparam int BEATS = NBYTES / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = $clog2(NBYTES);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if (!params_ok(NBYTES, LANES)) begin : g_bad_params
    $error("aes_subbytes_seq: illegal NBYTES=%0d LANES=%0d", NBYTES, LANES);
  end

  sb_state_t               state;
  sb_state_t               state_next;
  logic [BW-1:0]           beat;
  logic                    mode;
  logic [NBYTES-1:0][7:0]  src;
  logic [NBYTES-1:0][7:0]  res;
  logic [IW-1:0]           lane_idx [LANES];
  logic [7:0]              lane_in  [LANES];
  logic [7:0]              lane_out [LANES];
  logic                    accept;
  logic                    flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = S_RUN;
      S_RUN: begin
        if (bus.abort)               state_next = S_IDLE;
        else if (beat == LAST_BEAT)  state_next = S_DONE;
      end
      S_DONE: begin
        if (bus.abort || bus.out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // abort is only a flush when a block is in flight; in IDLE it merely blocks accept.
  always_comb begin
    bus.in_ready  = (state == S_IDLE) && resetn;
    bus.out_valid = (state == S_DONE);
    bus.busy      = (state != S_IDLE);
    bus.out_data  = res;
    accept        = bus.in_ready && bus.in_valid && !bus.abort;
    flush         = bus.abort && (state != S_IDLE);
  end

  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_idx[k] = IW'(32'(beat) * LANES + k);
      lane_in[k]  = src[lane_idx[k]];
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    aes_sbox_fi u_sbox (
      .din  (lane_in[k]),
      .inv  (mode),
      .dout (lane_out[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      beat <= '0;
      mode <= 1'b0;
      src  <= '0;
      res  <= '0;
    end else if (flush) begin
      beat <= '0;
      res  <= '0;
    end else begin
      if (accept) begin
        src  <= bus.in_data;
        mode <= bus.in_inv;
        beat <= '0;
      end
      if (state == S_RUN) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          res[lane_idx[k]] <= lane_out[k];
        end
        beat <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
      end
    end
  end

endmodule
